register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-read-port integer register file. Successor to the single-configuration two-port register file.
- Adds configurable width, depth and read-port count, and write-to-read bypass.
- Adds a pending-write scoreboard for pipeline hazard detection, and a post-reset initialisation sweep with a ready flag.
- Sits between decode (reads, reserves) and writeback (writes) in the processor pipeline.

Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: register index width; DEPTH = 2**ADDR_WIDTH.
- NUM_READ, 2: number of independent read ports, 1..4.
- ZERO_REG, 1: when 1, index 0 always reads 0 and ignores writes and reserves.
- SP_INDEX, 2: index loaded with SP_RESET during the init sweep.
- SP_RESET, 32'h0100_0000: stack-pointer initial value.
- BYPASS, 1: when 1, a same-cycle write is forwarded to matching reads.

Ports:
- clock, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- read_addr, input, NUM_READ*ADDR_WIDTH: port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- read_data, output, NUM_READ*DATA_WIDTH: registered read data per port.
- busy, output, NUM_READ: registered scoreboard bit for each read address.
- write_enable, input, 1: writeback strobe.
- write_addr, input, ADDR_WIDTH: writeback index.
- write_data, input, DATA_WIDTH: writeback value.
- reserve_enable, input, 1: marks reserve_addr as pending a write.
- reserve_addr, input, ADDR_WIDTH: index to reserve.
- flush, input, 1: clears all scoreboard bits.
- ready, output, 1: high once the init sweep is complete.

Behaviour:
- Reset (reset_n low, async):
  - state = INIT, sweep counter = 0, ready = 0.
  - read_data = 0, busy = 0, all scoreboard bits = 0.
  - The storage array itself is not async-reset; the sweep initialises it.
- INIT state:
  - Each clock writes mem[counter] = (counter == SP_INDEX) ? SP_RESET : 0, then counter increments.
  - On the edge that writes counter == DEPTH-1, the block moves to READY and ready goes to 1.
  - ready therefore rises on the DEPTH-th rising edge after reset_n deasserts (32 edges at default).
- INIT port behaviour:
  - write_enable, reserve_enable and flush are ignored.
  - read_data and busy hold 0.
- READY state: stays in READY until reset_n is asserted.
- Read (READY), 1-cycle latency; on each edge, for every port k with address A, priority is:
  - ZERO_REG && A == 0: 0.
  - Else BYPASS && write_enable && write_addr == A (and write_addr is not a suppressed x0): write_data.
  - Else mem[A] as held before the edge.
  - With BYPASS = 0 the pre-write value is returned.
- Write (READY):
  - If write_enable and not (ZERO_REG && write_addr == 0), mem[write_addr] <= write_data on the edge.
  - The write also clears scoreboard[write_addr].
- Scoreboard next state per entry, in priority order:
  1. flush: clear to 0.
  2. reserve_enable && reserve_addr == i (not suppressed x0): set to 1.
  3. write_enable && write_addr == i: clear to 0.
  4. Otherwise hold.
- Reserve and write to the same index in the same cycle: the reserve wins (a new producer is in flight).
- busy[k] is registered with read_data[k] and equals the scoreboard next-state value for A. It therefore reflects same-cycle set/clear. It is always 0 for x0 when ZERO_REG = 1.
- All read ports are independent. Identical addresses on several ports return identical data.
- reset_n asserted mid-operation or mid-sweep: immediately returns to INIT, discards scoreboard state, and re-sweeps all entries. The previous register contents are overwritten.
- Widths: no arithmetic other than the sweep counter. The counter is ADDR_WIDTH+1 bits wide so it cannot wrap before terminating.

Test Plan:
- Reset then idle: ready is 0 for 31 edges and 1 on edge 32. Afterwards, reading x2 gives 0x0100_0000 and reading x5 gives 0.
- Write x5 = 0xDEADBEEF with ports 0/1 reading x5 in the same cycle: BYPASS = 1 gives 0xDEADBEEF on both the next cycle. With BYPASS = 0 the first read gives 0 and the following read gives 0xDEADBEEF.
- Write x0 = 0x1234 and reserve x0: the following read of x0 gives 0 with busy 0.
- Reserve x7, then read x7: busy = 1. Writeback x7 = 9: the same-cycle read shows busy 0 and data 9. Reserve and write x7 together: busy stays 1.
- Reserve x3, x4, x6 on consecutive cycles, then pulse flush together with reserve x8: all busy bits read 0, including x8.
- Assert reset_n low mid-sweep and again after x9 = 0x55 is written: read_data and busy drop to 0 asynchronously. ready returns 32 edges after release. x9 then reads 0.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-read-port register file with write bypass, pending-write scoreboard
// and a post-reset initialisation sweep that gates normal operation.
module register_file_mp #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    NUM_READ   = 2,
  parameter int                    ZERO_REG   = 1,
  parameter int                    SP_INDEX   = 2,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = DATA_WIDTH'(32'h0100_0000),
  parameter int                    BYPASS     = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]            busy,
  input  logic                           write_enable,
  input  logic [ADDR_WIDTH-1:0]          write_addr,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic                           reserve_enable,
  input  logic [ADDR_WIDTH-1:0]          reserve_addr,
  input  logic                           flush,
  output logic                           ready
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam bit                  ZERO_EN   = (ZERO_REG != 0);
  localparam bit                  BYPASS_EN = (BYPASS != 0);
  localparam logic [ADDR_WIDTH:0] SP_CNT    = (ADDR_WIDTH+1)'(SP_INDEX);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH:0]     count_reg, count_next;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [DEPTH-1:0]        sb_reg, sb_next;

  logic                    active;
  logic                    wr_x0, rsv_x0;
  logic                    wr_act, rsv_act, flush_act;

  assign active    = (state_reg == ST_READY);
  assign ready     = active;
  assign wr_x0     = ZERO_EN && (write_addr == '0);
  assign rsv_x0    = ZERO_EN && (reserve_addr == '0);
  assign wr_act    = active && write_enable && !wr_x0;
  assign rsv_act   = active && reserve_enable && !rsv_x0;
  assign flush_act = active && flush;

  // Sweep counter is one bit wider than the index so its MSB marks completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_INIT;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    mem_we     = 1'b0;
    mem_waddr  = write_addr;
    mem_wdata  = write_data;
    case (state_reg)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = count_reg[ADDR_WIDTH-1:0];
        mem_wdata  = (count_reg == SP_CNT) ? SP_RESET : '0;
        count_next = count_reg + (ADDR_WIDTH+1)'(1);
        if (count_next[ADDR_WIDTH]) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        mem_we = wr_act;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Storage has no reset; the sweep is what initialises it.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // A reserve outranks a same-cycle writeback: a newer producer is in flight.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sb
      assign sb_next[gi] = flush_act                                            ? 1'b0 :
                           (rsv_act && (reserve_addr == ADDR_WIDTH'(gi)))       ? 1'b1 :
                           (wr_act  && (write_addr   == ADDR_WIDTH'(gi)))       ? 1'b0 :
                                                                                  sb_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb_reg <= '0;
    end else begin
      sb_reg <= sb_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd_next, rd_reg;
      logic                  busy_next, busy_reg;

      assign ra = read_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      // busy follows the scoreboard's next state so same-cycle set/clear is visible.
      always_comb begin
        rd_next   = '0;
        busy_next = 1'b0;
        if (active) begin
          if (ZERO_EN && (ra == '0)) begin
            rd_next   = '0;
            busy_next = 1'b0;
          end else begin
            if (BYPASS_EN && wr_act && (write_addr == ra)) begin
              rd_next = write_data;
            end else begin
              rd_next = mem[ra];
            end
            busy_next = sb_next[ra];
          end
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          rd_reg   <= '0;
          busy_reg <= 1'b0;
        end else begin
          rd_reg   <= rd_next;
          busy_reg <= busy_next;
        end
      end

      assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_reg;
      assign busy[gi]                               = busy_reg;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: bypassing and non-bypassing instances share
// stimulus and are checked against an array-based reference model.
module tb_register_file_mp;
  localparam int          AW    = 5;
  localparam int          DW    = 32;
  localparam int          NR    = 2;
  localparam int          DEPTH = 32;
  localparam logic [31:0] SP    = 32'h0100_0000;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR*AW-1:0]  read_addr = '0;
  logic [NR*DW-1:0]  rd_b, rd_nb;
  logic [NR-1:0]     busy_b, busy_nb;
  logic              ready_b, ready_nb;
  logic              write_enable = 1'b0;
  logic [AW-1:0]     write_addr = '0;
  logic [DW-1:0]     write_data = '0;
  logic              reserve_enable = 1'b0;
  logic [AW-1:0]     reserve_addr = '0;
  logic              flush = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_sb  [DEPTH];
  bit          m_ready;
  int          m_edges;

  logic [31:0] exp_b  [NR];
  logic [31:0] exp_nb [NR];
  logic        exp_busy [NR];
  logic        exp_ready;

  always #5 clock = ~clock;

  register_file_mp #(.BYPASS(1)) u_dut (
    .clock(clock), .reset_n(reset_n), .read_addr(read_addr), .read_data(rd_b),
    .busy(busy_b), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .reserve_enable(reserve_enable),
    .reserve_addr(reserve_addr), .flush(flush), .ready(ready_b)
  );

  register_file_mp #(.BYPASS(0)) u_dut_nb (
    .clock(clock), .reset_n(reset_n), .read_addr(read_addr), .read_data(rd_nb),
    .busy(busy_nb), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .reserve_enable(reserve_enable),
    .reserve_addr(reserve_addr), .flush(flush), .ready(ready_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic we, input int wa, input logic [31:0] wd,
                       input logic re, input int ra, input logic fl,
                       input int a0, input int a1);
    write_enable   = we;
    write_addr     = AW'(wa);
    write_data     = wd;
    reserve_enable = re;
    reserve_addr   = AW'(ra);
    flush          = fl;
    read_addr      = {AW'(a1), AW'(a0)};
  endtask

  task automatic idle(input int a0, input int a1);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, a0, a1);
  endtask

  // Predict outputs for the coming edge, advance the model, then compare.
  task automatic cycle(input string tag);
    bit nsb [DEPTH];
    int a;
    if (!m_ready) begin
      for (int k = 0; k < NR; k++) begin
        exp_b[k] = '0; exp_nb[k] = '0; exp_busy[k] = 1'b0;
      end
      m_mem[m_edges] = (m_edges == 2) ? SP : 32'h0;
      m_edges++;
      m_ready = (m_edges == DEPTH);
    end else begin
      nsb = m_sb;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) nsb[i] = 1'b0;
      end else begin
        if (write_enable && write_addr != 0)   nsb[write_addr]   = 1'b0;
        if (reserve_enable && reserve_addr != 0) nsb[reserve_addr] = 1'b1;
      end
      for (int k = 0; k < NR; k++) begin
        a = int'(read_addr[k*AW +: AW]);
        if (a == 0) begin
          exp_b[k] = '0; exp_nb[k] = '0; exp_busy[k] = 1'b0;
        end else begin
          exp_nb[k]   = m_mem[a];
          exp_b[k]    = (write_enable && int'(write_addr) == a) ? write_data : m_mem[a];
          exp_busy[k] = nsb[a];
        end
      end
      m_sb = nsb;
      if (write_enable && write_addr != 0) m_mem[write_addr] = write_data;
    end
    exp_ready = m_ready;
    @(posedge clock);
    #1;
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s.byp.d%0d", tag, k),  rd_b[k*DW +: DW],  exp_b[k]);
      chk($sformatf("%s.nob.d%0d", tag, k),  rd_nb[k*DW +: DW], exp_nb[k]);
      chk($sformatf("%s.byp.b%0d", tag, k),  32'(busy_b[k]),    32'(exp_busy[k]));
      chk($sformatf("%s.nob.b%0d", tag, k),  32'(busy_nb[k]),   32'(exp_busy[k]));
    end
    chk($sformatf("%s.rdy", tag),    32'(ready_b),  32'(exp_ready));
    chk($sformatf("%s.rdy_nb", tag), 32'(ready_nb), 32'(exp_ready));
    $display("[%0t] %s ra=%h we=%b wa=%0d wd=%h rsv=%b/%0d fl=%b -> rd=%h/%h busy=%b rdy=%b",
             $time, tag, read_addr, write_enable, write_addr, write_data,
             reserve_enable, reserve_addr, flush, rd_b, rd_nb, busy_b, ready_b);
  endtask

  // Async reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, ".rd"},   32'(rd_b | rd_nb),     32'h0);
    chk({tag, ".busy"}, 32'(busy_b | busy_nb), 32'h0);
    chk({tag, ".rdy"},  32'(ready_b | ready_nb), 32'h0);
    m_ready = 1'b0;
    m_edges = 0;
    for (int i = 0; i < DEPTH; i++) m_sb[i] = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    $display("[%0t] %s reset released", $time, tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 'x;
      m_sb[i]  = 1'b0;
    end
    idle(0, 0);
    #2;
    do_reset("rst0");
    for (int i = 0; i < DEPTH; i++) cycle($sformatf("sweep%0d", i));

    idle(2, 5);                                      cycle("rd_sp");
    drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 5, 5); cycle("wr5_byp");
    idle(5, 5);                                      cycle("rd5");
    drive(1'b1, 0, 32'h1234, 1'b1, 0, 1'b0, 0, 0);   cycle("wr_x0");
    idle(0, 5);                                      cycle("rd_x0");
    drive(1'b0, 0, 32'h0, 1'b1, 7, 1'b0, 7, 2);      cycle("rsv7");
    idle(7, 7);                                      cycle("rd7_busy");
    drive(1'b1, 7, 32'h9, 1'b0, 0, 1'b0, 7, 5);      cycle("wb7");
    drive(1'b1, 7, 32'hA, 1'b1, 7, 1'b0, 7, 7);      cycle("rsv_wb7");
    idle(7, 0);                                      cycle("rd7_again");
    drive(1'b0, 0, 32'h0, 1'b1, 3, 1'b0, 3, 4);      cycle("rsv3");
    drive(1'b0, 0, 32'h0, 1'b1, 4, 1'b0, 3, 4);      cycle("rsv4");
    drive(1'b0, 0, 32'h0, 1'b1, 6, 1'b0, 6, 7);      cycle("rsv6");
    drive(1'b0, 0, 32'h0, 1'b1, 8, 1'b1, 8, 3);      cycle("flush_rsv8");
    idle(4, 6);                                      cycle("rd_flushed");

    for (int n = 0; n < 800; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, 15),
            1'($urandom_range(0, 15) == 0),
            $urandom_range(0, 15), $urandom_range(0, 15));
      cycle($sformatf("rnd%0d", n));
    end

    idle(9, 2);
    do_reset("rst_run");
    for (int i = 0; i < 10; i++) cycle($sformatf("part%0d", i));
    do_reset("rst_mid");
    for (int i = 0; i < DEPTH; i++) cycle($sformatf("resweep%0d", i));
    drive(1'b1, 9, 32'h55, 1'b0, 0, 1'b0, 9, 2);     cycle("wr9");
    idle(9, 9);                                      cycle("rd9");
    do_reset("rst_after");
    for (int i = 0; i < DEPTH; i++) cycle($sformatf("sweep_b%0d", i));
    idle(9, 2);                                      cycle("rd9_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
